// File: rtl/uart_tx_frame_if.sv
// Host-side handshake bundle for uart_tx_frame.
// The host drives data/valid; the transmitter answers with ready.
interface uart_tx_frame_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, LSB-first data, optional parity, 1-2 stops.
// Bit timing is paced by an external single-cycle baud_tick strobe.
module uart_tx_frame #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            baud_tick,
   uart_tx_frame_if.slave  bus,
   output logic            tx_out,
   output logic            tx_busy,
   output logic            tx_done
);

   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_frame: DATA_W must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1..2");
   end
   if (PARITY_EN < 0 || PARITY_EN > 1 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_tx_frame: PARITY_EN/PARITY_ODD must be 0..1");
   end

   typedef enum logic [2:0] {
      IDLE, ARMED, START, DATA, PARITY, STOP
   } state_t;

   localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY_ODD != 0);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic              parity_bit, parity_nxt;
   logic [3:0]        bit_cnt, bit_nxt;
   logic              stop_cnt, stop_nxt;
   logic              out_nxt, busy_nxt, done_nxt;
   logic              accept;

   assign bus.tx_ready = (state == IDLE);
   assign accept       = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         tx_out     <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift_reg  <= shift_nxt;
         parity_bit <= parity_nxt;
         bit_cnt    <= bit_nxt;
         stop_cnt   <= stop_nxt;
         tx_out     <= out_nxt;
         tx_busy    <= busy_nxt;
         tx_done    <= done_nxt;
      end
   end

   // IDLE ignores baud_tick so acceptance never shortens the start bit.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = ARMED;
         ARMED:   if (baud_tick) state_nxt = START;
         START:   if (baud_tick) state_nxt = DATA;
         DATA: begin
            if (baud_tick && bit_cnt == LAST_BIT)
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY:  if (baud_tick) state_nxt = STOP;
         STOP: begin
            if (baud_tick && stop_cnt == LAST_STOP)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shift_nxt  = shift_reg;
      parity_nxt = parity_bit;
      bit_nxt    = bit_cnt;
      stop_nxt   = stop_cnt;
      out_nxt    = tx_out;
      busy_nxt   = tx_busy;
      done_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               shift_nxt  = bus.tx_data;
               parity_nxt = (^bus.tx_data) ^ ODD;
               busy_nxt   = 1'b1;
            end
         end
         ARMED: begin
            if (baud_tick) out_nxt = 1'b0;
         end
         START: begin
            if (baud_tick) begin
               out_nxt   = shift_reg[0];
               shift_nxt = shift_reg >> 1;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt != LAST_BIT) begin
                  out_nxt   = shift_reg[0];
                  shift_nxt = shift_reg >> 1;
                  bit_nxt   = bit_cnt + 4'd1;
               end else if (PARITY_EN != 0) begin
                  out_nxt = parity_bit;
               end else begin
                  out_nxt  = 1'b1;
                  stop_nxt = 1'b0;
               end
            end
         end
         PARITY: begin
            if (baud_tick) begin
               out_nxt  = 1'b1;
               stop_nxt = 1'b0;
            end
         end
         STOP: begin
            if (baud_tick) begin
               out_nxt = 1'b1;
               if (stop_cnt == LAST_STOP) begin
                  busy_nxt = 1'b0;
                  done_nxt = 1'b1;
               end else begin
                  stop_nxt = stop_cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule
